// File: rtl/udp_source_arbiter.sv
// Schedules UDP transmissions between the DAQ FIFO (source 0) and the SATA FIFO (source 1).
// Optional grant/timeout statistics ports are compiled in with `define UDP_ARB_STATS_EN.
module udp_source_arbiter #(
    parameter int IFG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FIFO_DEPTH     = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  arb_mode,
    input  logic [12:0] daq_fifo_count,
    input  logic [15:0] daq_payload_len,
    input  logic [12:0] sata_fifo_count,
    input  logic [15:0] sata_payload_len,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic        error_clear,
    output logic        eng_start,
    output logic        eng_select,
    output logic [15:0] eng_payload_len,
    output logic        busy,
    output logic        timeout_error,
    output logic        config_error
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [31:0] daq_grant_count,
    output logic [31:0] sata_grant_count,
    output logic [15:0] timeout_count
`endif
);

    // state     | meaning
    // IDLE      | evaluate eligibility, grant when enabled and engine ready
    // START     | one-cycle eng_start pulse
    // WAIT_DONE | wait for eng_done or timeout
    // GAP       | inter-packet gap of IFG_CYCLES cycles
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

    localparam logic [15:0] DEPTH_W  = 16'(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam bit          HAS_GAP  = (IFG_CYCLES > 0);

    state_t      state;
    logic        last_grant;
    logic [15:0] cnt;

    logic daq_perm, sata_perm, daq_len_ok, sata_len_ok;
    logic daq_elig, sata_elig, cfg_bad, grant_ok, pick;

    always_comb begin
        daq_perm    = (arb_mode != 2'd1);
        sata_perm   = (arb_mode != 2'd0);
        daq_len_ok  = (daq_payload_len != 16'd0) && (daq_payload_len <= DEPTH_W);
        sata_len_ok = (sata_payload_len != 16'd0) && (sata_payload_len <= DEPTH_W);
        daq_elig    = daq_perm && daq_len_ok && ({3'b0, daq_fifo_count} >= daq_payload_len);
        sata_elig   = sata_perm && sata_len_ok && ({3'b0, sata_fifo_count} >= sata_payload_len);
        cfg_bad     = (daq_perm && !daq_len_ok) || (sata_perm && !sata_len_ok);
        grant_ok    = enable && eng_ready && (daq_elig || sata_elig);
        // grant_ok already guarantees the chosen source is eligible in modes 0 and 1
        case (arb_mode)
            2'd0:    pick = 1'b0;
            2'd1:    pick = 1'b1;
            2'd2:    pick = last_grant ? !daq_elig : sata_elig;
            default: pick = !daq_elig;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            last_grant      <= 1'b1;
            cnt             <= 16'd0;
            eng_start       <= 1'b0;
            eng_select      <= 1'b0;
            eng_payload_len <= 16'd0;
            busy            <= 1'b0;
            timeout_error   <= 1'b0;
            config_error    <= 1'b0;
`ifdef UDP_ARB_STATS_EN
            daq_grant_count  <= 32'd0;
            sata_grant_count <= 32'd0;
            timeout_count    <= 16'd0;
`endif
        end else begin
            eng_start <= 1'b0;
            // a set later in this block overrides the clear
            if (error_clear) begin
                timeout_error <= 1'b0;
                config_error  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cfg_bad) config_error <= 1'b1;
                    if (grant_ok) begin
                        state           <= S_START;
                        eng_select      <= pick;
                        eng_payload_len <= pick ? sata_payload_len : daq_payload_len;
                        last_grant      <= pick;
                        eng_start       <= 1'b1;
                        busy            <= 1'b1;
`ifdef UDP_ARB_STATS_EN
                        if (!pick && daq_grant_count != '1) daq_grant_count <= daq_grant_count + 32'd1;
                        if (pick && sata_grant_count != '1) sata_grant_count <= sata_grant_count + 32'd1;
`endif
                    end
                end
                S_START: begin
                    state <= S_WAIT_DONE;
                    cnt   <= 16'd0;
                end
                S_WAIT_DONE: begin
                    if (eng_done || cnt == TO_LAST) begin
                        if (!eng_done) begin
                            timeout_error <= 1'b1;
`ifdef UDP_ARB_STATS_EN
                            if (timeout_count != '1) timeout_count <= timeout_count + 16'd1;
`endif
                        end
                        if (HAS_GAP) begin
                            state <= S_GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_source_arbiter.sv
// Directed bench for udp_source_arbiter with a small engine model answering eng_start.
module tb_udp_source_arbiter;

    localparam int IFG = 4;
    localparam int TMO = 100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  arb_mode = 2'd2;
    logic [12:0] daq_fifo_count = 13'd0;
    logic [15:0] daq_payload_len = 16'd512;
    logic [12:0] sata_fifo_count = 13'd0;
    logic [15:0] sata_payload_len = 16'd512;
    logic        eng_ready = 1'b1;
    logic        eng_done = 1'b0;
    logic        error_clear = 1'b0;
    logic        eng_start, eng_select, busy, timeout_error, config_error;
    logic [15:0] eng_payload_len;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_starts = 0;
    int done_delay = 20;
    int eng_cnt = 0;
    int s_prev, s_now, t_n, ok;

    udp_source_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4096)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .arb_mode(arb_mode),
        .daq_fifo_count(daq_fifo_count), .daq_payload_len(daq_payload_len),
        .sata_fifo_count(sata_fifo_count), .sata_payload_len(sata_payload_len),
        .eng_ready(eng_ready), .eng_done(eng_done), .error_clear(error_clear),
        .eng_start(eng_start), .eng_select(eng_select), .eng_payload_len(eng_payload_len),
        .busy(busy), .timeout_error(timeout_error), .config_error(config_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (eng_start) n_starts <= n_starts + 1;
    end

    // engine model: eng_done pulses done_delay cycles after the start cycle; 0 means never
    initial begin
        forever begin
            @(posedge clock);
            #1;
            eng_done = 1'b0;
            if (eng_start) begin
                eng_cnt = done_delay;
            end else if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) eng_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_start(input string tag, input int limit, output int at);
        int k;
        at = -1;
        for (k = 0; k < limit; k++) begin
            tick();
            if (eng_start === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 500; k++) begin
            tick();
            if (busy === 1'b0) break;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_start", {31'd0, eng_start}, 32'd0);
        chk("rst_select", {31'd0, eng_select}, 32'd0);
        chk("rst_len", {16'd0, eng_payload_len}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_error}, 32'd0);
        chk("rst_cfg", {31'd0, config_error}, 32'd0);
        tick();
        reset_n = 1'b1;

        // round-robin alternation, start spacing 22+IFG
        daq_fifo_count = 13'd1000;
        sata_fifo_count = 13'd1000;
        enable = 1'b1;
        s_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start("rr", 200, s_now);
            chk("rr_select", {31'd0, eng_select}, i % 2);
            chk("rr_len", {16'd0, eng_payload_len}, 32'd512);
            if (i > 0) chk("rr_spacing", s_now - s_prev, 22 + IFG);
            s_prev = s_now;
        end
        tick();
        chk("start_one_cycle", {31'd0, eng_start}, 32'd0);

        // DAQ priority, takes effect at next IDLE
        arb_mode = 2'd3;
        sata_payload_len = 16'd700;
        for (int i = 0; i < 2; i++) begin
            wait_start("prio", 200, s_now);
            chk("prio_select", {31'd0, eng_select}, 32'd0);
        end
        daq_fifo_count = 13'd100;
        wait_start("prio_fb", 200, s_now);
        chk("prio_fb_select", {31'd0, eng_select}, 32'd1);
        chk("prio_fb_len", {16'd0, eng_payload_len}, 32'd700);

        // DAQ only: one byte short, then exact fill
        enable = 1'b0;
        wait_idle("m0");
        arb_mode = 2'd0;
        daq_fifo_count = 13'd511;
        enable = 1'b1;
        t_n = n_starts;
        repeat (10) tick();
        chk("m0_short_nostart", n_starts - t_n, 32'd0);
        chk("m0_short_busy", {31'd0, busy}, 32'd0);
        daq_fifo_count = 13'd512;
        tick();
        chk("m0_latency", {31'd0, eng_start}, 32'd1);
        chk("m0_len", {16'd0, eng_payload_len}, 32'd512);
        chk("m0_select", {31'd0, eng_select}, 32'd0);

        // timeout: engine never finishes
        enable = 1'b0;
        wait_idle("tmo_pre");
        done_delay = 0;
        enable = 1'b1;
        wait_start("tmo", 50, s_now);
        enable = 1'b0;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (timeout_error === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("tmo_seen", ok, 32'd1);
        chk("tmo_delay", cyc - s_now, TMO + 1);
        chk("tmo_busy_gap", {31'd0, busy}, 32'd1);
        wait_idle("tmo_gap");
        chk("tmo_gap_len", cyc - s_now, TMO + 1 + IFG);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("tmo_clear", {31'd0, timeout_error}, 32'd0);
        done_delay = 20;

        // config errors
        arb_mode = 2'd1;
        sata_payload_len = 16'd0;
        enable = 1'b1;
        t_n = n_starts;
        repeat (3) tick();
        chk("cfg_sata_zero", {31'd0, config_error}, 32'd1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("cfg_set_wins", {31'd0, config_error}, 32'd1);
        repeat (5) tick();
        chk("cfg_nostart", n_starts - t_n, 32'd0);
        enable = 1'b0;
        arb_mode = 2'd0;
        sata_payload_len = 16'd700;
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("cfg_cleared", {31'd0, config_error}, 32'd0);
        daq_payload_len = 16'd5000;
        daq_fifo_count = 13'd8000;
        enable = 1'b1;
        t_n = n_starts;
        repeat (4) tick();
        chk("cfg_daq_big", {31'd0, config_error}, 32'd1);
        chk("cfg_big_nostart", n_starts - t_n, 32'd0);

        // async reset mid-packet restores round-robin pointer
        daq_payload_len = 16'd512;
        sata_fifo_count = 13'd1000;
        arb_mode = 2'd2;
        wait_start("rr2", 50, s_now);
        chk("rr2_select", {31'd0, eng_select}, 32'd1);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_len", {16'd0, eng_payload_len}, 32'd0);
        chk("arst_cfg", {31'd0, config_error}, 32'd0);
        tick();
        reset_n = 1'b1;
        wait_start("post_rst", 50, s_now);
        chk("post_rst_select", {31'd0, eng_select}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=expired expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
